// File: rtl/bus_slave_interface_pkg.sv
// bus_slave_interface_pkg: shared types and bus constants for the IO_bus slave
package bus_slave_interface_pkg;
  typedef logic [7:0] byte_t;
  typedef logic [31:0] uint32_t;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ACCESS, S_ACK, S_RELEASE} bus_slave_state_t;
  localparam logic BUS_READ = 1'b1;
  localparam logic BUS_WRITE = 1'b0;
endpackage

// File: rtl/IO_bus.sv
// IO_bus: internal 32-bit register bus between the uP-facing master and peripheral slaves
//  handshake_1/handshake_2 : 4-phase request/acknowledge pair
//  RW                      : 1 = read, 0 = write
//  reg_address             : byte register number, qualified by register_address_valid
//  data_out / data_in      : master-to-slave / slave-to-master data
//  nFault                  : active-low fault report from the slave
interface IO_bus;
  logic handshake_1;
  logic handshake_2;
  logic RW;
  logic [7:0] reg_address;
  logic register_address_valid;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic nFault;
  modport slave(input handshake_1, RW, reg_address, register_address_valid, data_out,
                output handshake_2, data_in, nFault);
  modport master(output handshake_1, RW, reg_address, register_address_valid, data_out,
                 input handshake_2, data_in, nFault);
endinterface

// File: rtl/bus_slave_FSM.sv
// bus_slave_FSM: handshake state machine and control decode for bus_slave_interface
//  clk, reset (async active-low), handshake1, selected, rwLatched in;
//  state, ldIndex, doWrite, doRead, ack, clrFault out
module bus_slave_FSM
  import bus_slave_interface_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             handshake1,
  input  logic             selected,
  input  logic             rwLatched,
  output bus_slave_state_t state,
  output logic             ldIndex,
  output logic             doWrite,
  output logic             doRead,
  output logic             ack,
  output logic             clrFault
);
  // armed: handshake_1 has been seen low since the last accepted request,
  // so a request still held high after a transaction cannot re-trigger
  logic armed;
  assign clrFault = state == S_IDLE && handshake1 && selected && armed;
  assign ldIndex = state == S_DECODE && handshake1;
  assign doWrite = state == S_ACCESS && rwLatched == BUS_WRITE;
  assign doRead = state == S_ACCESS && rwLatched == BUS_READ;
  assign ack = state == S_ACK && handshake1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      armed <= !handshake1 ? 1'b1 : (clrFault ? 1'b0 : armed);
      case (state)
        S_IDLE:   state <= clrFault ? S_DECODE : S_IDLE;
        S_DECODE: state <= handshake1 ? S_ACCESS : S_IDLE;
        S_ACCESS: state <= S_ACK;
        S_ACK:    state <= handshake1 ? S_ACK : S_RELEASE;
        default:  state <= S_IDLE;
      endcase
    end
endmodule

// File: rtl/bus_slave_interface.sv
// bus_slave_interface: IO_bus responder owning a window of RW config and RO status registers
//  clk, reset (async active-low), bus (IO_bus.slave),
//  config_regs/write_strobe out to the peripheral core, status_regs/periph_fault in.
//  Build option BUS_SLAVE_READBACK_EN: reads of RW registers return their contents (else 0).
module bus_slave_interface
  import bus_slave_interface_pkg::*;
#(
  parameter int BASE_ADDRESS = 0,
  parameter int NOS_RW_REGS  = 4,
  parameter int NOS_RO_REGS  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  IO_bus.slave                         bus,
  output logic [NOS_RW_REGS-1:0][31:0] config_regs,
  output logic [NOS_RW_REGS-1:0]       write_strobe,
  input  logic [NOS_RO_REGS-1:0][31:0] status_regs,
  input  logic                         periph_fault
);
  localparam int TOTAL = NOS_RW_REGS + NOS_RO_REGS;
  if (BASE_ADDRESS + TOTAL > 256) begin : gParamError
    $error("bus_slave_interface: register window exceeds 8-bit address space");
  end
  bus_slave_state_t state;
  logic [8:0] offset;
  logic selected, rwLatched, accessFault, ldIndex, doWrite, doRead, ack, clrFault;
  byte_t index;
  uint32_t readWord;
  // 9-bit difference: addresses below the base wrap above 255 and fall outside the window
  assign offset = {1'b0, bus.reg_address} - 9'(BASE_ADDRESS);
  assign selected = bus.register_address_valid && offset < 9'(TOTAL);
  assign bus.nFault = (state == S_IDLE && !selected) ? 1'b1 : !(accessFault || periph_fault);
  bus_slave_FSM uFsm (
    .clk(clk),
    .reset(reset),
    .handshake1(bus.handshake_1),
    .selected(selected),
    .rwLatched(rwLatched),
    .state(state),
    .ldIndex(ldIndex),
    .doWrite(doWrite),
    .doRead(doRead),
    .ack(ack),
    .clrFault(clrFault)
  );
  always_comb begin
    readWord = '0;
`ifdef BUS_SLAVE_READBACK_EN
    for (int i = 0; i < NOS_RW_REGS; i++)
      if (index == byte_t'(i)) readWord = config_regs[i];
`endif
    for (int i = 0; i < NOS_RO_REGS; i++)
      if (index == byte_t'(NOS_RW_REGS + i)) readWord = status_regs[i];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.handshake_2 <= 1'b0;
      bus.data_in <= '0;
      config_regs <= '0;
      write_strobe <= '0;
      index <= '0;
      rwLatched <= BUS_WRITE;
      accessFault <= 1'b0;
    end else begin
      bus.handshake_2 <= ack;
      // read data is held only while the acknowledge phase lasts
      bus.data_in <= doRead ? readWord : (ack ? bus.data_in : '0);
      if (ldIndex) begin
        index <= offset[7:0];
        rwLatched <= bus.RW;
      end
      if (clrFault) accessFault <= 1'b0;
      else if (doWrite && index >= byte_t'(NOS_RW_REGS)) accessFault <= 1'b1;
      for (int i = 0; i < NOS_RW_REGS; i++) begin
        write_strobe[i] <= doWrite && index == byte_t'(i);
        if (doWrite && index == byte_t'(i)) config_regs[i] <= bus.data_out;
      end
    end
endmodule
